// File: rtl/uart_tx_cfg.sv
// UART transmitter: byte FIFO feeding an LSB-first serialiser with optional parity
// and 1/2 stop bits; baud divisor and frame format are written over the config bus.
module uart_tx_cfg #(
    parameter int         PRESCALE       = 16,
    parameter logic [7:0] DEFAULT_DIV    = 8'd53,
    parameter int         FIFO_DEPTH     = 4,
    parameter logic [3:0] CFG_ADDR_BAUD  = 4'h6,
    parameter logic [3:0] CFG_ADDR_FRAME = 4'h7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       c_valid,
    input  logic [3:0] c_addr,
    input  logic [7:0] c_data,
    output logic       c_ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_t;

    state_t        state, state_n;
    logic [7:0]    baud_div;
    logic [2:0]    frame;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full, push, pop;
    logic [7:0]    head;
    logic [PW-1:0] pre_cnt;
    logic [7:0]    div_cnt, div_lat;
    logic [2:0]    bit_cnt;
    logic [1:0]    par_mode;
    logic          stop2, par_bit, par_en;
    logic [7:0]    shreg, shreg_n;
    logic          bit_end, frame_end, tx_n;

    // FIFO: extra pointer MSB separates full from empty
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign head     = mem[rd_ptr[AW-1:0]];
    assign busy     = (state != S_IDLE) || !empty;
    assign c_ready  = !busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= in_data;
    end

    // Only the low three FRAME bits have storage; the rest read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_div <= DEFAULT_DIV;
            frame    <= '0;
        end else if (c_valid && c_ready) begin
            if (c_addr == CFG_ADDR_BAUD)  baud_div <= c_data;
            if (c_addr == CFG_ADDR_FRAME) frame    <= 3'(c_data & 8'h07);
        end
    end

    assign bit_end = (pre_cnt == PRE_MAX) && (div_cnt == div_lat);
    assign par_en  = (par_mode == 2'b01) || (par_mode == 2'b10);

    // State register plus bit timing; counters restart on every pop and bit boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
            pre_cnt  <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            div_lat  <= DEFAULT_DIV;
            par_mode <= '0;
            stop2    <= 1'b0;
        end else begin
            state   <= state_n;
            tx      <= tx_n;
            tx_done <= frame_end;
            if (pop || bit_end) begin
                pre_cnt <= '0;
                div_cnt <= '0;
            end else if (pre_cnt == PRE_MAX) begin
                pre_cnt <= '0;
                div_cnt <= div_cnt + 8'd1;
            end else begin
                pre_cnt <= pre_cnt + PW'(1);
            end
            if (pop) begin
                bit_cnt  <= '0;
                div_lat  <= baud_div;
                par_mode <= frame[1:0];
                stop2    <= frame[2];
            end else if (state == S_DATA && bit_end) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_n;
        if (pop) par_bit <= (frame[1:0] == 2'b10) ? ~^head : ^head;
    end

    always_comb begin
        state_n   = state;
        pop       = 1'b0;
        frame_end = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = S_START;
                end
            end
            S_START:  if (bit_end) state_n = S_DATA;
            S_DATA:   if (bit_end && bit_cnt == 3'd7) state_n = par_en ? S_PARITY : S_STOP1;
            S_PARITY: if (bit_end) state_n = S_STOP1;
            S_STOP1: begin
                if (bit_end) begin
                    if (stop2) state_n = S_STOP2;
                    else       frame_end = 1'b1;
                end
            end
            S_STOP2:  if (bit_end) frame_end = 1'b1;
            default:  state_n = S_IDLE;
        endcase
        // A queued byte starts immediately after the last stop bit.
        if (frame_end) begin
            if (!empty) begin
                pop     = 1'b1;
                state_n = S_START;
            end else begin
                state_n = S_IDLE;
            end
        end
    end

    always_comb begin
        shreg_n = shreg;
        tx_n    = 1'b1;
        if (pop)                              shreg_n = head;
        else if (state == S_DATA && bit_end)  shreg_n = {1'b0, shreg[7:1]};
        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shreg_n[0];
            S_PARITY: tx_n = par_bit;
            default:  tx_n = 1'b1;
        endcase
    end
endmodule
